// File: rtl/connect4_scoreboard.sv
// -----------------------------------------------------------------------------
// connect4_scoreboard
//
// Score and turn tracker for the Connect-4 game datapath. Keeps one saturating
// score register per player, a modulo-NUM_PLAYERS turn pointer and a PLAY/OVER
// match state. The match ends on the edge where any player's score reaches
// WIN_SCORE. A combinational binary-to-BCD converter breaks the score of the
// player picked by disp_sel into three digits for the seven-segment drivers.
//
// Parameters
//   NUM_PLAYERS  number of players (2..8)
//   SCORE_W      width of each score register (1..7)
//   WIN_SCORE    score that ends the match (1..2^SCORE_W-1)
//   PID_W        width of the player index ports (derived)
//
// Ports
//   clock         system clock, rising edge
//   reset         synchronous, active-high reset
//   point_valid   award one point to point_player this cycle
//   point_player  player receiving the point
//   turn_advance  advance the turn pointer
//   clear_scores  start a new match (scores, turn, winner to 0; back to PLAY)
//   disp_sel      player whose score drives the BCD digits
//   score_flat    all scores, player i at [i*SCORE_W +: SCORE_W]
//   turn          current player to move
//   leader        lowest index among the players holding the top score
//   tie_top       two or more players share the top score
//   match_over    match state is OVER
//   winner        player who reached WIN_SCORE (meaningful while match_over)
//   bad_player    registered one-cycle pulse for a rejected point request
//   disp_hund/disp_tens/disp_ones  BCD digits of the selected score,
//                 all 4'hF (blank) when disp_sel is not a valid player
// -----------------------------------------------------------------------------
module connect4_scoreboard #(
   parameter int NUM_PLAYERS = 2,
   parameter int SCORE_W     = 7,
   parameter int WIN_SCORE   = 10,
   parameter int PID_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           point_valid,
   input  logic [PID_W-1:0]               point_player,
   input  logic                           turn_advance,
   input  logic                           clear_scores,
   input  logic [PID_W-1:0]               disp_sel,
   output logic [NUM_PLAYERS*SCORE_W-1:0] score_flat,
   output logic [PID_W-1:0]               turn,
   output logic [PID_W-1:0]               leader,
   output logic                           tie_top,
   output logic                           match_over,
   output logic [PID_W-1:0]               winner,
   output logic                           bad_player,
   output logic [3:0]                     disp_hund,
   output logic [3:0]                     disp_tens,
   output logic [3:0]                     disp_ones
);

   typedef enum logic {
      ST_PLAY = 1'b0,
      ST_OVER = 1'b1
   } state_t;

   // One bit wider than a player index so NUM_PLAYERS itself is representable
   // and out-of-range indices can be detected for any player count.
   localparam logic [PID_W:0]       NP_L      = NUM_PLAYERS[PID_W:0];
   localparam logic [PID_W-1:0]     LAST_P    = PID_W'(NUM_PLAYERS - 1);
   localparam logic [SCORE_W-1:0]   WIN_L     = WIN_SCORE[SCORE_W-1:0];
   localparam logic [SCORE_W-1:0]   SCORE_MAX = {SCORE_W{1'b1}};

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t                 state_q, state_d;
   logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
   logic [PID_W-1:0]       turn_q, turn_d;
   logic [PID_W-1:0]       winner_q, winner_d;
   logic                   bad_q, bad_d;

   logic                   point_ok;
   logic                   disp_ok;

   assign point_ok = ({1'b0, point_player} < NP_L);
   assign disp_ok  = ({1'b0, disp_sel} < NP_L);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch; a path that
      // leaves one unassigned would infer a latch.
      state_d  = state_q;
      turn_d   = turn_q;
      winner_d = winner_q;
      bad_d    = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         score_d[i] = score_q[i];
      end

      if (clear_scores) begin
         // New match: wins over any point or turn request in the same cycle,
         // and a point request swallowed here is not reported as rejected.
         state_d  = ST_PLAY;
         turn_d   = '0;
         winner_d = '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_d[i] = '0;
         end
      end else begin
         unique case (state_q)
            ST_PLAY: begin
               if (point_valid) begin
                  if (point_ok) begin
                     for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (point_player == PID_W'(i)) begin
                           if (score_q[i] != SCORE_MAX) begin
                              score_d[i] = score_q[i] + 1'b1;
                           end
                           // Compare the post-increment value so the match
                           // closes on the same edge the winning point lands.
                           if (score_d[i] == WIN_L) begin
                              state_d  = ST_OVER;
                              winner_d = point_player;
                           end
                        end
                     end
                  end else begin
                     bad_d = 1'b1;
                  end
               end
               if (turn_advance) begin
                  turn_d = (turn_q == LAST_P) ? '0 : turn_q + 1'b1;
               end
            end
            ST_OVER: begin
               // Scores, turn and winner are frozen; a point request is
               // flagged so the game controller sees it was dropped.
               if (point_valid) begin
                  bad_d = 1'b1;
               end
            end
            default: state_d = ST_PLAY;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      // NOTE: state is written with non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state_q  <= ST_PLAY;
         turn_q   <= '0;
         winner_q <= '0;
         bad_q    <= 1'b0;
         // NOTE: the score array is a handful of flops, not a RAM, so it is
         // reset like any other register; a real memory would not be.
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         turn_q   <= turn_d;
         winner_q <= winner_d;
         bad_q    <= bad_d;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_q[i] <= score_d[i];
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_flat
      assign score_flat[g*SCORE_W +: SCORE_W] = score_q[g];
   end

   assign turn       = turn_q;
   assign winner     = winner_q;
   assign bad_player = bad_q;
   assign match_over = (state_q == ST_OVER);

   // Leader scan: a strictly greater score takes the lead and clears the tie
   // flag; an equal score keeps the lower index and marks a tie.
   logic [SCORE_W-1:0] best;

   always_comb begin
      best    = score_q[0];
      leader  = '0;
      tie_top = 1'b0;
      for (int i = 1; i < NUM_PLAYERS; i++) begin
         if (score_q[i] > best) begin
            best    = score_q[i];
            leader  = PID_W'(i);
            tie_top = 1'b0;
         end else if (score_q[i] == best) begin
            tie_top = 1'b1;
         end
      end
   end

   // BCD breakdown of the selected score (double dabble). Scores never exceed
   // 127, so a 7-bit input and three digits always suffice.
   logic [SCORE_W-1:0] sel_score;
   logic [6:0]         bin;
   logic [11:0]        bcd;

   always_comb begin
      sel_score = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (disp_sel == PID_W'(i)) begin
            sel_score = score_q[i];
         end
      end

      bin = 7'(sel_score);
      bcd = '0;
      for (int b = 6; b >= 0; b--) begin
         if (bcd[3:0]  > 4'd4) bcd[3:0]  = bcd[3:0]  + 4'd3;
         if (bcd[7:4]  > 4'd4) bcd[7:4]  = bcd[7:4]  + 4'd3;
         if (bcd[11:8] > 4'd4) bcd[11:8] = bcd[11:8] + 4'd3;
         bcd = {bcd[10:0], bin[b]};
      end

      if (disp_ok) begin
         disp_hund = bcd[11:8];
         disp_tens = bcd[7:4];
         disp_ones = bcd[3:0];
      end else begin
         disp_hund = 4'hF;
         disp_tens = 4'hF;
         disp_ones = 4'hF;
      end
   end

endmodule

// File: tb/tb_connect4_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_connect4_scoreboard
//
// Three scoreboard instances with different parameter sets share one clock and
// reset; each has its own stimulus. A behavioural model (plain integer arrays)
// tracks what every instance must hold, and a compare process checks all
// outputs of all instances on every falling edge. Directed sequences add
// hand-computed literal expectations at key points.
//   inst 0: 2 players, 7-bit scores, win at 10
//   inst 1: 3 players, 7-bit scores, win at 127
//   inst 2: 3 players, 3-bit scores, win at 7
// -----------------------------------------------------------------------------
module tb_connect4_scoreboard;

   localparam int NP [3] = '{2, 3, 3};
   localparam int SW [3] = '{7, 7, 3};
   localparam int WN [3] = '{10, 127, 7};

   logic clock = 1'b0;
   logic reset = 1'b1;

   always #5 clock = ~clock;

   // Stimulus, one slot per instance
   int pv [3];
   int pp [3];
   int ta [3];
   int cs [3];
   int ds [3];

   // Instance 0
   logic [13:0] flat0;
   logic [0:0]  turn0, lead0, win0;
   logic        tie0, mo0, bad0;
   logic [3:0]  h0, t0, o0;
   // Instance 1
   logic [20:0] flat1;
   logic [1:0]  turn1, lead1, win1;
   logic        tie1, mo1, bad1;
   logic [3:0]  h1, t1, o1;
   // Instance 2
   logic [8:0]  flat2;
   logic [1:0]  turn2, lead2, win2;
   logic        tie2, mo2, bad2;
   logic [3:0]  h2, t2, o2;

   connect4_scoreboard #(.NUM_PLAYERS(2), .SCORE_W(7), .WIN_SCORE(10)) u_dut0 (
      .clock(clock), .reset(reset),
      .point_valid(pv[0][0]), .point_player(1'(pp[0])), .turn_advance(ta[0][0]),
      .clear_scores(cs[0][0]), .disp_sel(1'(ds[0])),
      .score_flat(flat0), .turn(turn0), .leader(lead0), .tie_top(tie0),
      .match_over(mo0), .winner(win0), .bad_player(bad0),
      .disp_hund(h0), .disp_tens(t0), .disp_ones(o0));

   connect4_scoreboard #(.NUM_PLAYERS(3), .SCORE_W(7), .WIN_SCORE(127)) u_dut1 (
      .clock(clock), .reset(reset),
      .point_valid(pv[1][0]), .point_player(2'(pp[1])), .turn_advance(ta[1][0]),
      .clear_scores(cs[1][0]), .disp_sel(2'(ds[1])),
      .score_flat(flat1), .turn(turn1), .leader(lead1), .tie_top(tie1),
      .match_over(mo1), .winner(win1), .bad_player(bad1),
      .disp_hund(h1), .disp_tens(t1), .disp_ones(o1));

   connect4_scoreboard #(.NUM_PLAYERS(3), .SCORE_W(3), .WIN_SCORE(7)) u_dut2 (
      .clock(clock), .reset(reset),
      .point_valid(pv[2][0]), .point_player(2'(pp[2])), .turn_advance(ta[2][0]),
      .clear_scores(cs[2][0]), .disp_sel(2'(ds[2])),
      .score_flat(flat2), .turn(turn2), .leader(lead2), .tie_top(tie2),
      .match_over(mo2), .winner(win2), .bad_player(bad2),
      .disp_hund(h2), .disp_tens(t2), .disp_ones(o2));

   // Actual outputs gathered per instance (zero-extended, X preserved)
   logic [63:0] a_flat [3];
   logic [7:0]  a_turn [3], a_lead [3], a_tie [3], a_mo [3], a_win [3];
   logic [7:0]  a_bad [3], a_h [3], a_t [3], a_o [3];

   assign a_flat[0] = 64'(flat0); assign a_flat[1] = 64'(flat1); assign a_flat[2] = 64'(flat2);
   assign a_turn[0] = 8'(turn0);  assign a_turn[1] = 8'(turn1);  assign a_turn[2] = 8'(turn2);
   assign a_lead[0] = 8'(lead0);  assign a_lead[1] = 8'(lead1);  assign a_lead[2] = 8'(lead2);
   assign a_tie[0]  = 8'(tie0);   assign a_tie[1]  = 8'(tie1);   assign a_tie[2]  = 8'(tie2);
   assign a_mo[0]   = 8'(mo0);    assign a_mo[1]   = 8'(mo1);    assign a_mo[2]   = 8'(mo2);
   assign a_win[0]  = 8'(win0);   assign a_win[1]  = 8'(win1);   assign a_win[2]  = 8'(win2);
   assign a_bad[0]  = 8'(bad0);   assign a_bad[1]  = 8'(bad1);   assign a_bad[2]  = 8'(bad2);
   assign a_h[0]    = 8'(h0);     assign a_h[1]    = 8'(h1);     assign a_h[2]    = 8'(h2);
   assign a_t[0]    = 8'(t0);     assign a_t[1]    = 8'(t1);     assign a_t[2]    = 8'(t2);
   assign a_o[0]    = 8'(o0);     assign a_o[1]    = 8'(o1);     assign a_o[2]    = 8'(o2);

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input int k,
                        input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d: got %0d, expected %0d (t=%0t)",
                  name, k, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: scores as plain integers, match state as a flag
   // ---------------------------------------------------------------------------
   int m_sc [3][8];
   int m_turn [3];
   int m_over [3];
   int m_win [3];
   int m_bad [3];

   function automatic int max_score(input int k);
      return (1 << SW[k]) - 1;
   endfunction

   always @(posedge clock) begin
      for (int k = 0; k < 3; k++) begin
         if (reset || cs[k] != 0) begin
            for (int i = 0; i < 8; i++) m_sc[k][i] <= 0;
            m_turn[k] <= 0;
            m_over[k] <= 0;
            m_win[k]  <= 0;
            m_bad[k]  <= 0;
         end else if (m_over[k] == 0) begin
            m_bad[k] <= 0;
            if (pv[k] != 0) begin
               if (pp[k] < NP[k]) begin
                  m_sc[k][pp[k]] <= (m_sc[k][pp[k]] >= max_score(k)) ? max_score(k)
                                                                      : m_sc[k][pp[k]] + 1;
                  if (m_sc[k][pp[k]] + 1 == WN[k]) begin
                     m_over[k] <= 1;
                     m_win[k]  <= pp[k];
                  end
               end else begin
                  m_bad[k] <= 1;
               end
            end
            if (ta[k] != 0) m_turn[k] <= (m_turn[k] + 1) % NP[k];
         end else begin
            m_bad[k] <= (pv[k] != 0) ? 1 : 0;
         end
      end
   end

   function automatic longint exp_flat(input int k);
      longint f = 0;
      for (int i = 0; i < NP[k]; i++) f += longint'(m_sc[k][i]) << (i * SW[k]);
      return f;
   endfunction

   function automatic int exp_leader(input int k);
      int best = -1;
      int ld = 0;
      for (int i = 0; i < NP[k]; i++) begin
         if (m_sc[k][i] > best) begin
            best = m_sc[k][i];
            ld = i;
         end
      end
      return ld;
   endfunction

   function automatic int exp_tie(input int k);
      int best = 0;
      int cnt = 0;
      for (int i = 0; i < NP[k]; i++) if (m_sc[k][i] > best) best = m_sc[k][i];
      for (int i = 0; i < NP[k]; i++) if (m_sc[k][i] == best) cnt++;
      return (cnt >= 2) ? 1 : 0;
   endfunction

   // digit: 2 = hundreds, 1 = tens, 0 = ones
   function automatic int exp_digit(input int k, input int digit);
      int s;
      if (ds[k] >= NP[k]) return 15;
      s = m_sc[k][ds[k]];
      case (digit)
         2:       return s / 100;
         1:       return (s / 10) % 10;
         default: return s % 10;
      endcase
   endfunction

   always @(negedge clock) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            check("score_flat", k, a_flat[k], exp_flat(k));
            check("turn",       k, a_turn[k], m_turn[k]);
            check("leader",     k, a_lead[k], exp_leader(k));
            check("tie_top",    k, a_tie[k],  exp_tie(k));
            check("match_over", k, a_mo[k],   m_over[k]);
            check("winner",     k, a_win[k],  m_win[k]);
            check("bad_player", k, a_bad[k],  m_bad[k]);
            check("disp_hund",  k, a_h[k],    exp_digit(k, 2));
            check("disp_tens",  k, a_t[k],    exp_digit(k, 1));
            check("disp_ones",  k, a_o[k],    exp_digit(k, 0));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus with literal expectations
   // ---------------------------------------------------------------------------
   // Inputs change 1 time unit after the rising edge; the literal checks that
   // follow a step() therefore see the state produced by that edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic point(input int k, input int p);
      pv[k] = 1;
      pp[k] = p;
      step();
      pv[k] = 0;
   endtask

   task automatic clear(input int k);
      cs[k] = 1;
      step();
      cs[k] = 0;
   endtask

   int turn_seq [5] = '{1, 2, 0, 1, 2};

   initial begin
      for (int k = 0; k < 3; k++) begin
         pv[k] = 0; pp[k] = 0; ta[k] = 0; cs[k] = 0; ds[k] = 0;
      end
      reset = 1'b1;
      step();
      step();
      reset  = 1'b0;
      chk_en = 1'b1;

      // Reset state
      check("rst_flat",   0, a_flat[0], 0);
      check("rst_leader", 0, a_lead[0], 0);
      check("rst_tie",    0, a_tie[0],  1);
      check("rst_over",   0, a_mo[0],   0);
      check("rst_bad",    0, a_bad[0],  0);
      check("rst_ones",   0, a_o[0],    0);

      // 3 points to P0, 1 to P1
      point(0, 0); point(0, 0); point(0, 0); point(0, 1);
      check("t1_flat",   0, a_flat[0], (1 << 7) | 3);
      check("t1_leader", 0, a_lead[0], 0);
      check("t1_tie",    0, a_tie[0],  0);
      check("t1_hund",   0, a_h[0],    0);
      check("t1_tens",   0, a_t[0],    0);
      check("t1_ones",   0, a_o[0],    3);

      // 10 consecutive points to P1 from a fresh match
      clear(0);
      check("t2_clear", 0, a_flat[0], 0);
      for (int i = 0; i < 10; i++) begin
         point(0, 1);
         check("t2_over", 0, a_mo[0], (i == 9) ? 1 : 0);
      end
      check("t2_winner", 0, a_win[0], 1);
      point(0, 1);
      check("t2_hold", 0, a_flat[0], 10 << 7);
      check("t2_bad",  0, a_bad[0],  1);
      step();
      check("t2_bad_end", 0, a_bad[0], 0);
      check("t2_still",   0, a_mo[0],  1);

      // clear + point together while OVER
      cs[0] = 1; pv[0] = 1; pp[0] = 0;
      step();
      cs[0] = 0; pv[0] = 0;
      check("t5_flat", 0, a_flat[0], 0);
      check("t5_over", 0, a_mo[0],   0);
      check("t5_bad",  0, a_bad[0],  0);

      // Turn sequence with 3 players
      ta[1] = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t3_turn", 1, a_turn[1], turn_seq[i]);
      end
      ta[1] = 0;

      // Point and turn advance in the same cycle
      pv[1] = 1; pp[1] = 2; ta[1] = 1;
      step();
      pv[1] = 0; ta[1] = 0;
      check("both_turn", 1, a_turn[1], 0);
      check("both_flat", 1, a_flat[1], 1 << 14);

      // Out-of-range player and blank display
      point(1, 3);
      check("t4_flat", 1, a_flat[1], 1 << 14);
      check("t4_bad",  1, a_bad[1],  1);
      ds[1] = 3;
      #1;
      check("t4_hund", 1, a_h[1], 15);
      check("t4_tens", 1, a_t[1], 15);
      check("t4_ones", 1, a_o[1], 15);
      step();
      check("t4_bad_end", 1, a_bad[1], 0);
      ds[1] = 0;

      // Leader/tie: lowest index wins a tie
      point(1, 1);
      check("tie_leader", 1, a_lead[1], 1);
      check("tie_flag",   1, a_tie[1],  1);
      point(1, 2);
      check("lead_leader", 1, a_lead[1], 2);
      check("lead_tie",    1, a_tie[1],  0);

      // Win at the score ceiling
      clear(1);
      for (int i = 0; i < 126; i++) point(1, 0);
      check("t6_126",  1, a_flat[1], 126);
      check("t6_open", 1, a_mo[1],   0);
      point(1, 0);
      check("t6_flat", 1, a_flat[1], 127);
      check("t6_over", 1, a_mo[1],   1);
      check("t6_win",  1, a_win[1],  0);
      check("t6_hund", 1, a_h[1],    1);
      check("t6_tens", 1, a_t[1],    2);
      check("t6_ones", 1, a_o[1],    7);
      ta[1] = 1;
      step();
      ta[1] = 0;
      check("t6_turn_frozen", 1, a_turn[1], 0);

      // 3-bit scores: reach 7, further points do not wrap
      for (int i = 0; i < 7; i++) point(2, 1);
      check("sat_flat", 2, a_flat[2], 7 << 3);
      check("sat_over", 2, a_mo[2],   1);
      check("sat_win",  2, a_win[2],  1);
      point(2, 1);
      check("sat_hold", 2, a_flat[2], 7 << 3);
      ds[2] = 1;
      #1;
      check("sat_ones", 2, a_o[2], 7);

      // Reset in the middle of a match
      point(0, 0);
      point(0, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_flat0", 0, a_flat[0], 0);
      check("mid_tie0",  0, a_tie[0],  1);
      check("mid_over1", 1, a_mo[1],   0);
      check("mid_flat1", 1, a_flat[1], 0);
      check("mid_flat2", 2, a_flat[2], 0);
      check("mid_win2",  2, a_win[2],  0);

      step();
      step();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
